// File: rtl/cpu_pkg.sv
// Shared definitions for the load/store unit.
//   - request size encodings (byte / halfword / word / reserved)
//   - LSU controller state enum
//   - alignment check used to reject requests before any memory access
package cpu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // True when the request cannot be serviced: the reserved size code is
    // folded in so a single check drives the error path.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the LSU (little-endian lanes).
// Ports:
//   word        - 32-bit word read from memory
//   wdata       - store data, right-aligned for byte/halfword
//   offset      - byte offset within the word (addr[1:0])
//   size        - request size encoding
//   is_unsigned - 1: zero-extend loads, 0: sign-extend
//   load_data   - extracted and extended load result
//   merged      - word with the addressed lane(s) replaced by wdata
module lsu_lane_align
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = 8'(word >> {offset, 3'b000});
        lane_half = 16'(word >> {offset[1], 4'b0000});
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{~is_unsigned & lane_half[15]}}, lane_half};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the pipeline and a word-organised data memory.
// Byte/halfword stores use read-modify-write; loads return extended data.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_*             - request handshake and fields (byte address)
//   rsp_valid/err/rdata - one-cycle completion pulse with status and load data
//   mem_addr/we/wdata - word address, write enable and write data to memory
//   mem_rdata         - combinational read data for mem_addr
module lsu_mem_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    lsu_state_t        state_next;

    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [1:0]        lat_off;
    logic [ADDR_W-1:0] lat_waddr;
    logic [31:0]       wr_word;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_bad;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign accept  = req_valid && (state == ST_IDLE);
    assign req_bad = is_misaligned(req_size, req_addr[1:0]);

    lsu_lane_align u_align (
        .word        (mem_rdata),
        .wdata       (wr_word),
        .offset      (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad)                 state_next = ST_RESP;
                    else if (!req_we)            state_next = ST_RD;
                    else if (req_size == SZ_WORD) state_next = ST_WR;
                    else                         state_next = ST_RD;
                end
            end
            ST_RD:   state_next = lat_we ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    // wr_word holds the raw store data from accept until RD, where it is
    // overwritten with the merged word; word stores use it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we       <= 1'b0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_off      <= '0;
            lat_waddr    <= '0;
            wr_word      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_addr[1:0];
                        lat_waddr    <= req_addr[ADDR_W+1:2];
                        wr_word      <= req_wdata;
                        err_q        <= req_bad;
                        rdata_q      <= '0;
                    end
                end
                ST_RD: begin
                    if (lat_we) wr_word <= merged;
                    else        rdata_q <= load_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        rsp_err   = (state == ST_RESP) && err_q;
        rsp_rdata = rdata_q;
        mem_we    = (state == ST_WR);
        mem_wdata = (state == ST_WR) ? wr_word : '0;
        mem_addr  = (state == ST_IDLE) ? req_addr[ADDR_W+1:2] : lat_waddr;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the CPU execute/memory stage and the word-organised data memory.
- Takes byte-addressed byte, halfword and word requests from the pipeline.
- Drives the memory's word address, write-enable and write-data, and consumes its combinational read data.
- Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data with a fixed latency.

Parameters:
- ADDR_W, 14, word-address width of the data memory; the byte address is ADDR_W+2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00=byte, 01=halfword, 10=word, 11=reserved.
- req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  input  ADDR_W+2  byte address.
- req_wdata  input  32  store data; right-aligned for byte/halfword.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  qualified by rsp_valid; misaligned or reserved-size request.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- mem_addr  output  ADDR_W  word address to the data memory.
- mem_we  output  1  memory write enable; the memory writes on the clk rising edge.
- mem_wdata  output  32  word written to memory.
- mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- Data layout: little-endian byte lanes. Byte k of a word occupies bits [8k+7:8k]. Word address is req_addr[ADDR_W+1:2].
- States:
  - IDLE: req_ready=1.
  - RD: sample mem_rdata.
  - WR: mem_we=1.
  - RESP: rsp_valid=1 for exactly one cycle, then back to IDLE.
- Accept: a request is taken on the edge where req_valid && req_ready. All request fields are latched, and the request inputs are ignored until the next IDLE.
- Transitions on accept:
  - Error: size 11, halfword with addr[0]=1, or word with addr[1:0]!=0 go straight to RESP with rsp_err=1. No memory access is made and mem_we is never asserted.
  - Load: IDLE->RD->RESP. In RD, mem_addr=latched word address. At the RD->RESP edge the selected lane is extracted, extended per req_unsigned, and registered into rsp_rdata.
  - Word store: IDLE->WR->RESP. In WR, mem_wdata=latched wdata.
  - Byte/halfword store: IDLE->RD->WR->RESP. At the RD->WR edge the merged word is registered: mem_rdata with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. In WR, mem_wdata=merged word.
- Latency (accept edge to rsp_valid cycle):
  - Error: 1 cycle.
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Back-to-back: no overlap; the next accept is at the earliest in the cycle after RESP.
- Output decode:
  - mem_we is 1 only in WR, decoded from state.
  - mem_addr holds the latched word address in every non-IDLE state, and req_addr's word address in IDLE.
  - mem_wdata is 0 outside WR.
- Reset: asynchronous reset forces IDLE and clears all registers. Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_wdata=0.
- Reset mid-operation: the request is dropped. If rst_n falls during WR before the edge, mem_we drops immediately and no write occurs; memory contents are left untouched. No response is produced for the aborted request.
- No response backpressure: the consumer must take rsp_valid in its pulse cycle.

Decomposition:
- Shared package (cpu_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - the state enum.
  - the misalignment-check function.
- Sub-module lsu_lane_align, purely combinational:
  - load extract plus sign/zero extend.
  - store merge: old word, new data, offset, size -> merged word.
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- Word store 0xDEADBEEF to byte addr 0x0014 -> mem_we high exactly one cycle with mem_addr=5 and mem_wdata=0xDEADBEEF; rsp_valid 2 cycles after accept with rsp_err=0.
- Word at 0x14 = 0xDEADBEEF; byte store 0x5A to addr 0x0016 -> one RD then one WR; memory word 5 becomes 0xDE5ABEEF; rsp_valid 3 cycles after accept.
- Word 5 = 0x80F07F01:
  - signed byte load addr 0x0016 -> rsp_rdata=0xFFFFFFF0.
  - unsigned byte load addr 0x0016 -> rsp_rdata=0x000000F0.
  - signed half load addr 0x0016 -> rsp_rdata=0xFFFF80F0.
- Misaligned: half load at 0x0015, word store at 0x0016, size=11 -> rsp_err=1 one cycle after accept; mem_we never asserted; memory unchanged.
- Reset during WR of a sub-word store (rst_n low mid-cycle, before the edge) -> mem_we falls combinationally; memory word unchanged; no rsp_valid; req_ready=1 after rst_n rises.
- Back-to-back stream of 8 mixed requests with req_valid held high -> each accepted only in IDLE; responses in order; read-back matches a reference model byte for byte.
